// File: rtl/ofmap_writeback_queue_pkg.sv
// Shared types and helpers for the output-feature-map writeback queue.
// Widths here describe the default build; the top re-derives them from its parameters.
package ofmap_writeback_queue_pkg;

  localparam int unsigned NumBanksDef  = 4;
  localparam int unsigned NumColsDef   = 32;
  localparam int unsigned MaxBitsDef   = 8;
  localparam int unsigned AddrWidthDef = 32;
  localparam int unsigned ChanBitsDef  = 16;

  typedef enum logic {
    IDLE,
    ISSUE
  } wb_state_e;

  typedef struct packed {
    logic [NumBanksDef*NumColsDef*MaxBitsDef-1:0] data;
    logic [AddrWidthDef-1:0]                      base;
    logic [ChanBitsDef-1:0]                       num_channels;
    logic                                         mode_4bit;
  } wb_entry_t;

  // Bytes enabled for a bank holding valid_ch live elements.
  function automatic int unsigned strb_bytes(input int unsigned valid_ch,
                                             input logic        is_4bit,
                                             input int unsigned max_bits);
    return is_4bit ? (valid_ch + 32'd1) / 32'd2 : (valid_ch * max_bits) / 32'd8;
  endfunction

endpackage

// File: rtl/ofmap_writeback_queue_wb_entry_fifo.sv
// Synchronous FIFO of queue entries; exposes the head and the entry behind it
// so the drain side can move to the next row without a bubble.
module ofmap_writeback_queue_wb_entry_fifo
  import ofmap_writeback_queue_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned Depth   = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    push_i,
  input  entry_t                  push_entry_i,
  input  logic                    pop_i,
  output entry_t                  head_o,
  output entry_t                  next_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PtrW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_writeback_queue.sv
// Queues full output rows and serialises each into one buffer write per active bank,
// with 8-bit or 4-bit packing and byte strobes for partial channel counts.
//   state | meaning
//   IDLE  | queue empty, no write presented
//   ISSUE | presenting bank bank_q of the head entry (wr_valid_o=0 for a zero-channel entry)
module ofmap_writeback_queue
  import ofmap_writeback_queue_pkg::*;
#(
  parameter int unsigned numBanks   = 4,
  parameter int unsigned numCols    = 32,
  parameter int unsigned maxBits    = 8,
  parameter int unsigned queueDepth = 4,
  parameter int unsigned addrWidth  = 32,
  parameter int unsigned chanBits   = 16,
  parameter int unsigned writeWidth = numCols * maxBits
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [numBanks*numCols*maxBits-1:0] data_i,
  input  logic [addrWidth-1:0]              addr_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [chanBits-1:0]               cfg_num_channels_i,
  input  logic                              cfg_4bit_i,
  output logic [addrWidth-1:0]              wr_addr_o,
  output logic [writeWidth-1:0]             wr_data_o,
  output logic [writeWidth/8-1:0]           wr_strb_o,
  output logic                              wr_valid_o,
  input  logic                              wr_ready_i,
  output logic                              busy_o
);

  localparam int unsigned BankW = (numBanks > 1) ? $clog2(numBanks) : 1;
  localparam int unsigned RowW  = numCols * maxBits;
  localparam int unsigned StrbW = writeWidth / 8;
  localparam int unsigned CntW  = $clog2(queueDepth) + 1;

  typedef struct packed {
    logic [numBanks*numCols*maxBits-1:0] data;
    logic [addrWidth-1:0]                base;
    logic [chanBits-1:0]                 num_channels;
    logic                                mode_4bit;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  entry_t            next_head;
  entry_t            sel_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;

  wb_state_e         state_q;
  logic [BankW-1:0]  bank_q;
  logic [BankW-1:0]  bank_d;
  logic              wr_valid_q;
  logic              wr_valid_d;
  logic [addrWidth-1:0]  wr_addr_q;
  logic [addrWidth-1:0]  wr_addr_d;
  logic [writeWidth-1:0] wr_data_q;
  logic [writeWidth-1:0] wr_data_d;
  logic [StrbW-1:0]      wr_strb_q;
  logic [StrbW-1:0]      wr_strb_d;

  int unsigned       nxt_bank;
  int unsigned       bank_lo;
  int unsigned       nch;
  int unsigned       valid_ch;
  int unsigned       n_bytes;
  logic [RowW-1:0]   slice;
  logic              last_bank;
  logic              advance;
  logic              pop;

  assign push_entry = '{data: data_i, base: addr_i,
                        num_channels: cfg_num_channels_i, mode_4bit: cfg_4bit_i};

  ofmap_writeback_queue_wb_entry_fifo #(
    .entry_t (entry_t),
    .Depth   (queueDepth)
  ) u_fifo (
    .clk          (clk),
    .nrst         (nrst),
    .push_i       (valid_i),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .next_o       (next_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  // Active banks are always a prefix 0..k, so the next one is simply bank_q+1.
  always_comb begin
    nxt_bank  = 32'(bank_q) + 32'd1;
    last_bank = !((nxt_bank < numBanks) &&
                  (32'(head.num_channels) > nxt_bank * numCols));
    advance   = (state_q == ISSUE) && (!wr_valid_q || wr_ready_i);
    pop       = advance && last_bank;
  end

  always_comb begin
    sel_entry = head;
    bank_d    = '0;
    if (state_q == ISSUE) begin
      if (last_bank) sel_entry = next_head;
      else           bank_d    = BankW'(nxt_bank);
    end
  end

  always_comb begin
    bank_lo    = 32'(bank_d) * numCols;
    nch        = 32'(sel_entry.num_channels);
    wr_valid_d = (nch > bank_lo);
    valid_ch   = 0;
    if (wr_valid_d) valid_ch = (nch - bank_lo > numCols) ? numCols : nch - bank_lo;
    slice      = sel_entry.data[32'(bank_d)*RowW +: RowW];
    n_bytes    = strb_bytes(valid_ch, sel_entry.mode_4bit, maxBits);
    wr_strb_d  = '0;
    for (int unsigned i = 0; i < StrbW; i++) wr_strb_d[i] = (i < n_bytes);
    wr_data_d  = '0;
    if (sel_entry.mode_4bit) begin
      // Elements past valid_ch stay zero so an odd tail leaves its upper nibble clear.
      for (int unsigned e = 0; e < numCols; e++) begin
        if (e < valid_ch) wr_data_d[e*4 +: 4] = slice[e*maxBits +: 4];
      end
      wr_addr_d = sel_entry.base + addrWidth'(bank_lo / 32'd2);
    end else begin
      wr_data_d = writeWidth'(slice);
      wr_addr_d = sel_entry.base + addrWidth'(bank_lo * maxBits / 32'd8);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ISSUE;
            bank_q     <= bank_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
          end
        end
        ISSUE: begin
          if (advance) begin
            if (last_bank && fifo_count == CntW'(1)) begin
              state_q    <= IDLE;
              wr_valid_q <= 1'b0;
            end else begin
              bank_q     <= bank_d;
              wr_valid_q <= wr_valid_d;
              wr_addr_q  <= wr_addr_d;
              wr_data_q  <= wr_data_d;
              wr_strb_q  <= wr_strb_d;
            end
          end
        end
      endcase
    end
  end

  assign ready_o    = !fifo_full;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign wr_strb_o  = wr_strb_q;
  assign busy_o     = (fifo_count != '0) || wr_valid_q;

endmodule

// File: tb/tb_ofmap_writeback_queue.sv
// Bench for ofmap_writeback_queue: rows are expanded into expected writes by a
// behavioural model and compared with the writes observed on the buffer port.
module tb_ofmap_writeback_queue;

  localparam int NB = 4, NC = 32, MB = 8, AW = 32, CW = 16;
  localparam int WW = NC * MB, RW = NB * NC * MB;

  typedef struct {
    logic [31:0]     addr;
    logic [WW-1:0]   data;
    logic [WW/8-1:0] strb;
    logic [WW-1:0]   mask;
  } wr_t;

  logic clk = 1'b0, nrst = 1'b1;
  logic [RW-1:0]   data_i = '0;
  logic [AW-1:0]   addr_i = '0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [CW-1:0]   cfg_num_channels_i = '0;
  logic            cfg_4bit_i = 1'b0;
  logic [AW-1:0]   wr_addr_o;
  logic [WW-1:0]   wr_data_o;
  logic [WW/8-1:0] wr_strb_o;
  logic            wr_valid_o;
  logic            wr_ready_i = 1'b0;
  logic            busy_o;

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, stall_viol = 0;
  bit rr_en = 1'b0, rdy_force = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0]   p_addr;
  logic [WW-1:0]   p_data;
  logic [WW/8-1:0] p_strb;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  obs_cyc[$];

  ofmap_writeback_queue dut (
    .clk(clk), .nrst(nrst), .data_i(data_i), .addr_i(addr_i), .valid_i(valid_i),
    .ready_o(ready_o), .cfg_num_channels_i(cfg_num_channels_i), .cfg_4bit_i(cfg_4bit_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    wr_ready_i = rr_en ? ($urandom_range(0, 1) == 1) : rdy_force;
  end

  // Expected writes for one accepted row, straight from the channel/bank rules.
  function automatic void expand(input logic [RW-1:0] d, input logic [31:0] a,
                                 input int n, input bit m);
    for (int b = 0; b < NB; b++) begin
      int  vc;
      wr_t w;
      if (n <= b * NC) break;
      vc = (n - b * NC > NC) ? NC : n - b * NC;
      w.data = '0; w.strb = '0; w.mask = '1;
      if (!m) begin
        w.addr = a + 32'(b * NC);
        w.data = d[b*WW +: WW];
        for (int k = 0; k < vc; k++) w.strb[k] = 1'b1;
      end else begin
        w.addr = a + 32'(b * NC / 2);
        for (int e = 0; e < vc; e++) w.data[e*4 +: 4] = d[(b*NC+e)*8 +: 4];
        w.mask = '0;
        w.mask[WW-1:WW/2] = '1;
        for (int k = 0; k < (vc + 1) / 2; k++) begin
          w.strb[k] = 1'b1;
          w.mask[k*8 +: 8] = 8'hFF;
        end
      end
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!wr_valid_o || wr_addr_o !== p_addr ||
                         wr_data_o !== p_data || wr_strb_o !== p_strb))
        stall_viol++;
      prev_stall = wr_valid_o && !wr_ready_i;
      p_addr = wr_addr_o; p_data = wr_data_o; p_strb = wr_strb_o;
      if (wr_valid_o && wr_ready_i) begin
        wr_t w;
        w.addr = wr_addr_o; w.data = wr_data_o; w.strb = wr_strb_o; w.mask = '0;
        obs_q.push_back(w);
        obs_cyc.push_back(cyc);
      end
      if (valid_i && ready_o) begin
        acc_cyc = cyc;
        expand(data_i, addr_i, int'(cfg_num_channels_i), cfg_4bit_i);
      end
    end
  end

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_sb();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic push_row(input logic [RW-1:0] d, input logic [31:0] a,
                          input int n, input bit m);
    int k = 0;
    @(posedge clk); #1;
    data_i = d; addr_i = a; cfg_num_channels_i = CW'(n); cfg_4bit_i = m; valid_i = 1'b1;
    while (!ready_o && k < 400) begin @(posedge clk); #1; k++; end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL push_timeout ready_o=%b after %0d cycles, required 1", ready_o, k);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while (busy_o && k < 500);
    if (busy_o) begin
      total++; bad++;
      $display("FAIL %s_drain_timeout busy_o=%b, required 0", tag, busy_o);
    end
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    total++; if (ready_o !== 1'b1)   begin bad++; $display("FAIL rst_ready got %b exp 1", ready_o); end
    total++; if (wr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got %b exp 0", wr_valid_o); end
    total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    total++; if (wr_addr_o !== '0)   begin bad++; $display("FAIL rst_addr got %h exp 0", wr_addr_o); end
    total++; if (wr_strb_o !== '0)   begin bad++; $display("FAIL rst_strb got %h exp 0", wr_strb_o); end
    total++; if (wr_data_o !== '0)   begin bad++; $display("FAIL rst_data got nonzero exp 0"); end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_8bit_full();
    clear_sb();
    push_row(rand_row(), 32'h100, 128, 1'b0);
    wait_idle("full8");
    total++;
    if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
      bad++; $display("FAIL full8_count got %0d exp %0d (model %0d)", obs_q.size(), 4, exp_q.size());
    end else begin
      total++; if (obs_cyc[0] !== acc_cyc + 2) begin bad++; $display("FAIL full8_latency got %0d exp %0d", obs_cyc[0] - acc_cyc, 2); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_q[i].addr !== 32'h100 + 32'(i * 32) || obs_q[i].strb !== 32'hFFFF_FFFF ||
            obs_q[i].data !== exp_q[i].data || obs_cyc[i] !== obs_cyc[0] + i) begin
          bad++;
          $display("FAIL full8_w%0d got a=%h s=%h cyc+%0d exp a=%h s=ffffffff cyc+%0d", i,
                   obs_q[i].addr, obs_q[i].strb, obs_cyc[i] - obs_cyc[0], 32'h100 + 32'(i * 32), i);
        end
      end
    end
  endtask

  task automatic test_8bit_partial();
    clear_sb();
    push_row(rand_row(), 32'h100, 40, 1'b0);
    wait_idle("part8");
    total++;
    if (obs_q.size() !== 2) begin
      bad++; $display("FAIL part8_count got %0d exp 2", obs_q.size());
    end else begin
      total++; if (obs_q[0].addr !== 32'h100 || obs_q[0].strb !== 32'hFFFF_FFFF)
        begin bad++; $display("FAIL part8_w0 got a=%h s=%h exp a=100 s=ffffffff", obs_q[0].addr, obs_q[0].strb); end
      total++; if (obs_q[1].addr !== 32'h120 || obs_q[1].strb !== 32'h0000_00FF)
        begin bad++; $display("FAIL part8_w1 got a=%h s=%h exp a=120 s=000000ff", obs_q[1].addr, obs_q[1].strb); end
      total++; if (obs_q[1].data !== exp_q[1].data)
        begin bad++; $display("FAIL part8_data1 got %h exp %h", obs_q[1].data[63:0], exp_q[1].data[63:0]); end
    end
  endtask

  task automatic test_4bit();
    logic [RW-1:0] row = rand_row();
    logic [7:0] e32;
    e32 = row[32*8 +: 8];
    clear_sb();
    push_row(row, 32'h200, 37, 1'b1);
    wait_idle("pk4");
    total++;
    if (obs_q.size() !== 2) begin
      bad++; $display("FAIL pk4_count got %0d exp 2", obs_q.size());
    end else begin
      total++; if (obs_q[0].addr !== 32'h200 || obs_q[0].strb !== 32'h0000_FFFF)
        begin bad++; $display("FAIL pk4_w0 got a=%h s=%h exp a=200 s=0000ffff", obs_q[0].addr, obs_q[0].strb); end
      total++; if (obs_q[1].addr !== 32'h210 || obs_q[1].strb !== 32'h0000_0007)
        begin bad++; $display("FAIL pk4_w1 got a=%h s=%h exp a=210 s=00000007", obs_q[1].addr, obs_q[1].strb); end
      total++; if (obs_q[1].data[23:20] !== 4'h0)
        begin bad++; $display("FAIL pk4_odd_nibble got %h exp 0", obs_q[1].data[23:20]); end
      total++; if (obs_q[1].data[3:0] !== e32[3:0])
        begin bad++; $display("FAIL pk4_elem32 got %h exp %h", obs_q[1].data[3:0], e32[3:0]); end
      for (int i = 0; i < 2; i++) begin
        total++;
        if ((obs_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask))
          begin bad++; $display("FAIL pk4_data%0d got %h exp %h", i, obs_q[i].data[127:0], exp_q[i].data[127:0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0, seen = 0;
    clear_sb();
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 4; r++) push_row(rand_row(), 32'h1000 + 32'(r * 'h100), 128, 1'b0);
    @(posedge clk); #1;
    data_i = rand_row(); addr_i = 32'h5000; cfg_num_channels_i = 16'd128; cfg_4bit_i = 1'b0; valid_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %b exp 0", ready_o); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL bp_stalled_writes got %0d exp 0", obs_q.size()); end
    rdy_force = 1'b1;
    while (!ready_o && k < 100) begin @(negedge clk); #1; k++; end
    seen = obs_q.size();
    @(posedge clk); #1;
    valid_i = 1'b0;
    total++; if (seen !== 5) begin bad++; $display("FAIL bp_ready_rise writes_seen=%0d exp 5", seen); end
    wait_idle("bp");
    total++; if (obs_q.size() !== 20 || exp_q.size() !== 20)
      begin bad++; $display("FAIL bp_count got %0d exp 20 (model %0d)", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].strb !== exp_q[i].strb ||
          (obs_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask))
        begin bad++; $display("FAIL bp_sb[%0d] got a=%h s=%h exp a=%h s=%h", i, obs_q[i].addr, obs_q[i].strb, exp_q[i].addr, exp_q[i].strb); end
    end
  endtask

  task automatic test_random();
    clear_sb();
    stall_viol = 0;
    rr_en = 1'b1;
    for (int r = 0; r < 14; r++) begin
      int n;
      case ($urandom_range(0, 5))
        0: n = 0;
        1: n = 32;
        2: n = 33;
        default: n = int'($urandom_range(1, 128));
      endcase
      if (r == 2) n = 0;
      push_row(rand_row(), $urandom & 32'hFFFF_FFF0, n, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle("rnd");
    rr_en = 1'b0;
    total++; if (obs_q.size() !== exp_q.size())
      begin bad++; $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].strb !== exp_q[i].strb ||
          (obs_q[i].data & exp_q[i].mask) !== (exp_q[i].data & exp_q[i].mask))
        begin bad++; $display("FAIL rnd_sb[%0d] got a=%h s=%h exp a=%h s=%h", i, obs_q[i].addr, obs_q[i].strb, exp_q[i].addr, exp_q[i].strb); end
    end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL rnd_stall_stable got %0d changes exp 0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    int k = 0, snap;
    clear_sb();
    rdy_force = 1'b1;
    @(posedge clk);
    push_row(rand_row(), 32'h3000, 128, 1'b0);
    push_row(rand_row(), 32'h4000, 128, 1'b0);
    while (obs_q.size() < 1 && k < 50) begin @(negedge clk); #1; k++; end
    total++; if (obs_q.size() < 1) begin bad++; $display("FAIL rmid_start got %0d writes exp >=1", obs_q.size()); end
    @(negedge clk); #1;
    nrst = 1'b0;
    #1;
    snap = obs_q.size();
    exp_q.delete();
    total++; if (wr_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid got %b exp 0", wr_valid_o); end
    total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL rmid_busy got %b exp 0", busy_o); end
    total++; if (ready_o !== 1'b1)    begin bad++; $display("FAIL rmid_ready got %b exp 1", ready_o); end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    total++; if (obs_q.size() !== snap) begin bad++; $display("FAIL rmid_no_writes got %0d exp %0d", obs_q.size(), snap); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_idle_busy got %b exp 0", busy_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_8bit_full();
    test_8bit_partial();
    test_4bit();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
